// File: rtl/arb_grant_mux_pkg.sv
// rtl/arb_grant_mux_pkg.sv - shared constants and helpers for the grant mux slice
//
// Purpose: buffer depth constant, the widest channel count the index helper
// handles, and a one-hot to binary index encoder used to recover the winning
// channel number from the accepted-beat vector.
// Ports: none (package).

package arb_grant_mux_pkg;

    // Depth of the output buffer behind the grant mux.
    localparam int unsigned BUF_DEPTH = 2;

    // Largest channel count the index encoder supports.
    localparam int unsigned MAX_CH = 32;
    localparam int unsigned MAX_IW = 5;

    // OR-fold of the positions of every set bit. For a one-hot vector this is
    // the bit position; for an all-zero vector it is 0. No priority chain is
    // built, so the encoder stays a flat OR tree.
    function automatic logic [MAX_IW-1:0] onehot_index(input logic [MAX_CH-1:0] vec);
        logic [MAX_IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(MAX_CH); i++) begin
            if (vec[i]) begin
                idx = idx | MAX_IW'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_grant_mux_skid_buf2.sv
// rtl/arb_grant_mux_skid_buf2.sv - two-entry FIFO holding beats behind the grant mux
//
// Purpose: stores up to two beats in acceptance order. Push writes at wr_ptr,
// pop advances rd_ptr; rd_data always shows the oldest entry so the head is
// stable while it waits to be popped.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   push       in   write push_data this cycle (ignored when full)
//   push_data  in   W-bit entry to write
//   pop        in   drop the head entry this cycle (ignored when empty)
//   rd_data    out  W-bit head entry
//   count      out  number of stored entries (0..2)
//   full       out  count == 2
//   empty      out  count == 0

module skid_buf2
    import arb_grant_mux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [0:1];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'(BUF_DEPTH));
    assign empty   = (count == 2'd0);

    // Guard both operations so a misbehaving caller cannot corrupt the count.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/arb_grant_mux.sv
// rtl/arb_grant_mux.sv - request masking, grant mux and packet lock in front of a 2-entry buffer
//
// Purpose: sits beside a round-robin arbiter. Builds the arbiter's request
// vector from N valid/ready channels, consumes the same-cycle one-hot grant,
// muxes the winning beat into a two-entry buffer and keeps a multi-beat packet
// locked to its source until its last beat. Priority is only advanced on last
// beats so a packet's owner stays on top for the whole packet.
// Ports:
//   clk             in   clock
//   rst             in   asynchronous active-high reset
//   in_valid        in   N   per-channel beat valid
//   in_data         in   N*W per-channel payload, channel k at [k*W +: W]
//   in_last         in   N   per-channel last-beat flag
//   in_ready        out  N   beat accepted when valid & ready
//   arb_request     out  N   request vector to the arbiter
//   arb_grant       in   N   at-most-one-hot grant from the arbiter
//   arb_anygnt      in   1   arbiter any-grant
//   arb_update_pri  out  1   advance arbiter priority past the winner
//   out_valid       out  1   buffered beat valid
//   out_data        out  W   buffered payload
//   out_last        out  1   buffered last flag
//   out_src         out  SW  channel index that produced the beat
//   out_ready       in   1   downstream accepts when out_valid & out_ready

module arb_grant_mux
    import arb_grant_mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           in_valid,
    input  logic [N*W-1:0]         in_data,
    input  logic [N-1:0]           in_last,
    output logic [N-1:0]           in_ready,
    output logic [N-1:0]           arb_request,
    input  logic [N-1:0]           arb_grant,
    input  logic                   arb_anygnt,
    output logic                   arb_update_pri,
    output logic                   out_valid,
    output logic [W-1:0]           out_data,
    output logic                   out_last,
    output logic [$clog2(N)-1:0]   out_src,
    input  logic                   out_ready
);

    localparam int SW = $clog2(N);
    localparam int BW = W + 1 + SW;

    // Buffer handshake and state
    logic [1:0]    buf_count;
    logic          buf_full;
    logic          buf_empty;
    logic [BW-1:0] buf_rd_data;
    logic          space;
    logic          pop;

    // Lock state
    logic          lock;
    logic [SW-1:0] lock_src;
    logic [N-1:0]  lock_mask;

    // Winning beat
    logic [N-1:0]      accept;
    logic [MAX_CH-1:0] accept_ext;
    logic              push;
    logic [W-1:0]      win_data;
    logic              win_last;
    logic [SW-1:0]     win_idx;

    // Space comes from the registered count only. A full buffer refuses a
    // push even if it pops in the same cycle, which keeps out_ready off every
    // combinational path back to in_ready and arb_request.
    assign space = (buf_count < 2'(BUF_DEPTH));

    assign lock_mask = N'(1) << lock_src;

    // While full, nothing is requested, so the arbiter sees no grant and its
    // priority stays put. While locked, only the owning channel is requested.
    assign arb_request = space ? (lock ? (in_valid & lock_mask) : in_valid) : '0;

    // arb_anygnt is redundant with |arb_grant for a well-behaved arbiter; it
    // is folded in so a stray grant bit without any-grant is not accepted.
    assign in_ready = arb_grant & {N{space & arb_anygnt}};

    // A grant on a channel that is not valid produces no push.
    assign accept = in_valid & in_ready;
    assign push   = |accept;

    // One-hot AND-OR mux: at most one accept bit is set, so OR-ing the gated
    // lanes selects the winner without a priority chain.
    always_comb begin
        win_data = '0;
        win_last = 1'b0;
        for (int k = 0; k < N; k++) begin
            win_data = win_data | (in_data[k*W +: W] & {W{accept[k]}});
            win_last = win_last | (in_last[k] & accept[k]);
        end
    end

    always_comb begin
        accept_ext         = '0;
        accept_ext[N-1:0]  = accept;
    end

    assign win_idx = SW'(onehot_index(accept_ext));

    // Only a last beat releases the winner's top priority.
    assign arb_update_pri = push & win_last;

    // Lock follows the packet: set on a non-last beat, cleared on the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock     <= 1'b0;
            lock_src <= '0;
        end else if (push) begin
            if (win_last) begin
                lock <= 1'b0;
            end else begin
                lock     <= 1'b1;
                lock_src <= win_idx;
            end
        end
    end

    assign pop = out_valid & out_ready;

    skid_buf2 #(
        .W (BW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({win_data, win_last, win_idx}),
        .pop       (pop),
        .rd_data   (buf_rd_data),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign out_valid = ~buf_empty;
    assign out_data  = buf_rd_data[BW-1 -: W];
    assign out_last  = buf_rd_data[SW];
    assign out_src   = buf_rd_data[SW-1:0];

    // buf_full duplicates the space term above; kept for visibility in waves.
    logic unused_full;
    assign unused_full = buf_full;

endmodule

// File: tb/tb_arb_grant_mux.sv
// tb/tb_arb_grant_mux.sv - directed self-checking bench for arb_grant_mux with a round-robin arbiter stand-in

module tb_arb_grant_mux;

    localparam int N = 4;
    localparam int W = 8;

    logic          clk;
    logic          rst;
    logic [N-1:0]  in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_last;
    logic [N-1:0]  in_ready;
    logic [N-1:0]  arb_request;
    logic [N-1:0]  arb_grant;
    logic          arb_anygnt;
    logic          arb_update_pri;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic [1:0]    out_src;
    logic          out_ready;

    int n_checks;
    int n_pass;

    arb_grant_mux #(
        .N (N),
        .W (W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .arb_request    (arb_request),
        .arb_grant      (arb_grant),
        .arb_anygnt     (arb_anygnt),
        .arb_update_pri (arb_update_pri),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_last       (out_last),
        .out_src        (out_src),
        .out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round-robin arbiter stand-in, top priority starts at channel 0.
    logic [1:0] pri;

    function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [1:0] p);
        logic [3:0] g;
        logic [1:0] j;
        g = '0;
        for (int i = 0; i < 4; i++) begin
            j = p + 2'(i);
            if (req[j] && g == 4'd0) g[j] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [1:0] idx4(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    assign arb_grant  = rr_pick(arb_request, pri);
    assign arb_anygnt = |arb_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pri <= 2'd0;
        else if (arb_update_pri) pri <= idx4(arb_grant) + 2'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive_ch(input int k, input logic v, input logic [7:0] d, input logic l);
        in_valid[k]     = v;
        in_data[k*W +: W] = d;
        in_last[k]      = l;
    endtask

    task automatic idle_inputs();
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        out_ready = 1'b0;
        idle_inputs();

        // 1: reset, then idle
        rst = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_out_data", 32'(out_data), 32'd0);
        check("idle_out_last", 32'(out_last), 32'd0);
        check("idle_out_src", 32'(out_src), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd0);
        check("idle_arb_request", 32'(arb_request), 32'd0);
        check("idle_update_pri", 32'(arb_update_pri), 32'd0);

        // 2: single beat from ch2
        step();
        out_ready = 1'b1;
        drive_ch(2, 1'b1, 8'hA5, 1'b1);
        @(negedge clk);
        check("t2_arb_request", 32'(arb_request), 32'h4);
        check("t2_in_ready", 32'(in_ready), 32'h4);
        check("t2_update_pri", 32'(arb_update_pri), 32'd1);
        step();
        idle_inputs();
        @(negedge clk);
        check("t2_out_valid", 32'(out_valid), 32'd1);
        check("t2_out_data", 32'(out_data), 32'hA5);
        check("t2_out_src", 32'(out_src), 32'd2);
        check("t2_out_last", 32'(out_last), 32'd1);
        step();
        @(negedge clk);
        check("t2_drained", 32'(out_valid), 32'd0);

        // 3: ch1 three-beat packet with ch3 waiting
        do_reset();
        out_ready = 1'b1;
        drive_ch(1, 1'b1, 8'd11, 1'b0);
        drive_ch(3, 1'b1, 8'h33, 1'b1);
        @(negedge clk);
        check("t3_b1_request", 32'(arb_request), 32'hA);
        check("t3_b1_in_ready", 32'(in_ready), 32'h2);
        check("t3_b1_update", 32'(arb_update_pri), 32'd0);
        step();
        drive_ch(1, 1'b1, 8'd12, 1'b0);
        @(negedge clk);
        check("t3_b2_request", 32'(arb_request), 32'h2);
        check("t3_b2_update", 32'(arb_update_pri), 32'd0);
        check("t3_o1_data", 32'(out_data), 32'd11);
        check("t3_o1_src", 32'(out_src), 32'd1);
        step();
        drive_ch(1, 1'b1, 8'd13, 1'b1);
        @(negedge clk);
        check("t3_b3_request", 32'(arb_request), 32'h2);
        check("t3_b3_update", 32'(arb_update_pri), 32'd1);
        check("t3_o2_data", 32'(out_data), 32'd12);
        check("t3_o2_src", 32'(out_src), 32'd1);
        step();
        drive_ch(1, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        check("t3_ch3_request", 32'(arb_request), 32'h8);
        check("t3_ch3_in_ready", 32'(in_ready), 32'h8);
        check("t3_ch3_update", 32'(arb_update_pri), 32'd1);
        check("t3_o3_data", 32'(out_data), 32'd13);
        check("t3_o3_src", 32'(out_src), 32'd1);
        check("t3_o3_last", 32'(out_last), 32'd1);
        step();
        idle_inputs();
        @(negedge clk);
        check("t3_o4_valid", 32'(out_valid), 32'd1);
        check("t3_o4_data", 32'(out_data), 32'h33);
        check("t3_o4_src", 32'(out_src), 32'd3);

        // 4: backpressure fills the buffer, then drains
        do_reset();
        out_ready = 1'b0;
        drive_ch(0, 1'b1, 8'h40, 1'b1);
        @(negedge clk);
        check("t4_b0_in_ready", 32'(in_ready), 32'h1);
        step();
        drive_ch(0, 1'b1, 8'h41, 1'b1);
        @(negedge clk);
        check("t4_b1_in_ready", 32'(in_ready), 32'h1);
        step();
        drive_ch(0, 1'b1, 8'h42, 1'b1);
        @(negedge clk);
        check("t4_full_in_ready", 32'(in_ready), 32'h0);
        check("t4_full_request", 32'(arb_request), 32'h0);
        check("t4_full_update", 32'(arb_update_pri), 32'd0);
        check("t4_head_data", 32'(out_data), 32'h40);
        step();
        @(negedge clk);
        check("t4_head_stable", 32'(out_data), 32'h40);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_no_bypass", 32'(in_ready), 32'h0);
        check("t4_pop0_data", 32'(out_data), 32'h40);
        step();
        @(negedge clk);
        check("t4_pop1_data", 32'(out_data), 32'h41);
        check("t4_third_in_ready", 32'(in_ready), 32'h1);
        step();
        idle_inputs();
        @(negedge clk);
        check("t4_pop2_data", 32'(out_data), 32'h42);
        step();
        @(negedge clk);
        check("t4_empty", 32'(out_valid), 32'd0);

        // 5: all channels valid, full throughput round robin
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) drive_ch(k, 1'b1, 8'(8'h50 + k), 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("t5_valid_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("t5_src_%0d", i), 32'(out_src), 32'(i % 4));
            check($sformatf("t5_data_%0d", i), 32'(out_data), 32'(8'h50 + (i % 4)));
        end
        #1 idle_inputs();

        // 6: reset while locked with a full buffer
        do_reset();
        out_ready = 1'b0;
        drive_ch(1, 1'b1, 8'h61, 1'b0);
        drive_ch(2, 1'b1, 8'h71, 1'b1);
        @(negedge clk);
        check("t6_first_grant", 32'(in_ready), 32'h2);
        step();
        drive_ch(1, 1'b1, 8'h62, 1'b0);
        @(negedge clk);
        check("t6_locked_request", 32'(arb_request), 32'h2);
        step();
        @(negedge clk);
        check("t6_full_request", 32'(arb_request), 32'h0);
        check("t6_full_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_out_valid", 32'(out_valid), 32'd0);
        check("t6_rst_out_data", 32'(out_data), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_unlocked_request", 32'(arb_request), 32'h6);
        check("t6_post_out_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
